// File: rtl/reg_file_mp.sv
// reg_file_mp: parametrised multi-port integer register file.
// NRP combinational read ports, two write ports (port 1 has priority on
// address conflicts), optional same-cycle write-to-read forwarding and a
// per-register busy scoreboard tracking in-flight destinations.
module reg_file_mp #(
    parameter int XLEN        = 32,
    parameter int NREGS       = 32,
    parameter int AW          = 5,
    parameter int NRP         = 2,
    parameter int BYPASS      = 1,
    parameter int HARDWIRE_X0 = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NRP*AW-1:0]    rs,
    output logic [NRP*XLEN-1:0]  rdata,
    output logic [NRP-1:0]       rs_busy,
    input  logic [1:0]           we,
    input  logic [2*AW-1:0]      rd,
    input  logic [2*XLEN-1:0]    wd,
    input  logic                 issue_valid,
    input  logic [AW-1:0]        issue_rd,
    output logic                 any_busy
);

    // True when the address is the hardwired zero register.
    function automatic logic is_x0(input logic [AW-1:0] addr);
        return (HARDWIRE_X0 != 0) && (addr == {AW{1'b0}});
    endfunction

    logic [XLEN-1:0]  regs_r [NREGS];
    logic [NREGS-1:0] busy_r;
    logic [NREGS-1:0] busy_nxt_s;

    logic [AW-1:0]    rd0_s;
    logic [AW-1:0]    rd1_s;
    logic [XLEN-1:0]  wd0_s;
    logic [XLEN-1:0]  wd1_s;
    logic             wr0_en_s;
    logic             wr1_en_s;
    logic             iss_en_s;

    assign rd0_s = rd[0 +: AW];
    assign rd1_s = rd[AW +: AW];
    assign wd0_s = wd[0 +: XLEN];
    assign wd1_s = wd[XLEN +: XLEN];

    // Qualify write and issue requests; anything aimed at a hardwired x0 is dropped.
    always_comb begin
        wr0_en_s = 1'b0;
        wr1_en_s = 1'b0;
        iss_en_s = 1'b0;
        if (is_x0(rd0_s)) begin
            wr0_en_s = 1'b0;
        end else begin
            wr0_en_s = we[0];
        end
        if (is_x0(rd1_s)) begin
            wr1_en_s = 1'b0;
        end else begin
            wr1_en_s = we[1];
        end
        if (is_x0(issue_rd)) begin
            iss_en_s = 1'b0;
        end else begin
            iss_en_s = issue_valid;
        end
    end

    // Register array update; port 1 is applied last so it wins a same-address conflict.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NREGS; k++) begin
                regs_r[k] <= {XLEN{1'b0}};
            end
        end else begin
            if (wr0_en_s) begin
                regs_r[rd0_s] <= wd0_s;
            end
            if (wr1_en_s) begin
                regs_r[rd1_s] <= wd1_s;
            end
        end
    end

    // Next busy state: a new issue beats a writeback to the same register.
    always_comb begin
        busy_nxt_s = busy_r;
        for (int k = 0; k < NREGS; k++) begin
            if (iss_en_s && (issue_rd == AW'(k))) begin
                busy_nxt_s[k] = 1'b1;
            end else if ((wr0_en_s && (rd0_s == AW'(k))) ||
                         (wr1_en_s && (rd1_s == AW'(k)))) begin
                busy_nxt_s[k] = 1'b0;
            end else begin
                busy_nxt_s[k] = busy_r[k];
            end
        end
    end

    // Busy scoreboard flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_r <= {NREGS{1'b0}};
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NRP; gi++) begin : g_rport
            logic [AW-1:0]   addr_s;
            logic [XLEN-1:0] data_s;

            assign addr_s = rs[gi*AW +: AW];

            // Read mux with optional forwarding; reset and x0 force zero so no
            // write data leaks out while reset is held.
            always_comb begin
                data_s = regs_r[addr_s];
                if (reset || is_x0(addr_s)) begin
                    data_s = {XLEN{1'b0}};
                end else if ((BYPASS != 0) && wr1_en_s && (rd1_s == addr_s)) begin
                    data_s = wd1_s;
                end else if ((BYPASS != 0) && wr0_en_s && (rd0_s == addr_s)) begin
                    data_s = wd0_s;
                end else begin
                    data_s = regs_r[addr_s];
                end
            end

            assign rdata[gi*XLEN +: XLEN] = data_s;
            // Busy is never forwarded: a same-cycle writeback clears it only at the edge.
            assign rs_busy[gi] = (reset || is_x0(addr_s)) ? 1'b0 : busy_r[addr_s];
        end
    endgenerate

    assign any_busy = reset ? 1'b0 : (|busy_r);

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: stimulus pushes expected values, a
// negedge monitor pops and compares them against the live outputs.
module tb_reg_file_mp;

    logic        clk;
    logic        reset;
    logic [9:0]  rs;
    logic [63:0] rdata;
    logic [1:0]  rs_busy;
    logic [1:0]  we;
    logic [9:0]  rd;
    logic [63:0] wd;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        any_busy;
    logic [63:0] rdata_b;
    logic [1:0]  rs_busy_b;
    logic        any_busy_b;

    reg_file_mp #(.BYPASS(1)) dut (
        .clk(clk), .reset(reset), .rs(rs), .rdata(rdata), .rs_busy(rs_busy),
        .we(we), .rd(rd), .wd(wd), .issue_valid(issue_valid),
        .issue_rd(issue_rd), .any_busy(any_busy)
    );

    reg_file_mp #(.BYPASS(0)) dut_nobyp (
        .clk(clk), .reset(reset), .rs(rs), .rdata(rdata_b), .rs_busy(rs_busy_b),
        .we(we), .rd(rd), .wd(wd), .issue_valid(issue_valid),
        .issue_rd(issue_rd), .any_busy(any_busy_b)
    );

    localparam int K_RDATA  = 0;
    localparam int K_BUSY   = 1;
    localparam int K_ANY    = 2;
    localparam int K_RDATAB = 3;
    localparam int K_ANYB   = 4;
    localparam int K_BUSYB  = 5;

    typedef struct {
        int          kind;
        int          port;
        logic [31:0] exp;
    } exp_t;

    exp_t  sb_q[$];
    string name_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect_v(input int kind, input int port, input logic [31:0] exp, input string nm);
        exp_t e;
        e.kind = kind;
        e.port = port;
        e.exp  = exp;
        sb_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor: compare every pending expectation against the settled outputs.
    exp_t        mon_e;
    string       mon_nm;
    logic [31:0] mon_act;
    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            mon_e  = sb_q.pop_front();
            mon_nm = name_q.pop_front();
            case (mon_e.kind)
                K_RDATA:  mon_act = rdata[mon_e.port*32 +: 32];
                K_BUSY:   mon_act = {31'd0, rs_busy[mon_e.port]};
                K_ANY:    mon_act = {31'd0, any_busy};
                K_RDATAB: mon_act = rdata_b[mon_e.port*32 +: 32];
                K_ANYB:   mon_act = {31'd0, any_busy_b};
                K_BUSYB:  mon_act = {31'd0, rs_busy_b[mon_e.port]};
                default:  mon_act = 32'hBADC0DE0;
            endcase
            n_checks++;
            if (mon_act !== mon_e.exp) begin
                n_fail++;
                $display("FAIL %s: got 0x%08h expected 0x%08h", mon_nm, mon_act, mon_e.exp);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] w, input logic [4:0] a0, input logic [31:0] d0,
                         input logic [4:0] a1, input logic [31:0] d1,
                         input logic iv, input logic [4:0] ird,
                         input logic [4:0] r0, input logic [4:0] r1);
        we          = w;
        rd          = {a1, a0};
        wd          = {d1, d0};
        issue_valid = iv;
        issue_rd    = ird;
        rs          = {r1, r0};
    endtask

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        step();
        step();
        reset = 1'b0;
        expect_v(K_RDATA, 0, 32'h0, "reset_rdata0");
        expect_v(K_RDATA, 1, 32'h0, "reset_rdata1");
        expect_v(K_ANY,   0, 32'h0, "reset_any_busy");

        // Basic write through port 0, then x0 write ignored.
        step(); drive(2'b01, 5'd1, 32'h12345678, 5'd0, 32'h0, 1'b0, 5'd0, 5'd1, 5'd1);
        step(); drive(2'b01, 5'd0, 32'hFFFFFFFF, 5'd0, 32'h0, 1'b0, 5'd0, 5'd1, 5'd0);
        expect_v(K_RDATA, 0, 32'h12345678, "wr_x1_port0");
        expect_v(K_RDATA, 1, 32'h00000000, "x0_no_bypass");
        step(); drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd1, 5'd1);
        expect_v(K_RDATA, 0, 32'h12345678, "rd_x1_p0");
        expect_v(K_RDATA, 1, 32'h12345678, "rd_x1_p1");
        step(); drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd1);
        expect_v(K_RDATA, 0, 32'h00000000, "x0_after_write");

        // Same-address conflict: port 1 wins, also for forwarding.
        step(); drive(2'b11, 5'd5, 32'hAAAA0000, 5'd5, 32'h5555FFFF, 1'b0, 5'd0, 5'd5, 5'd1);
        expect_v(K_RDATA, 0, 32'h5555FFFF, "bypass_p1_prio");
        step(); drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd5);
        expect_v(K_RDATA, 0, 32'h5555FFFF, "conflict_x5_p0");
        expect_v(K_RDATA, 1, 32'h5555FFFF, "conflict_x5_p1");

        // Forwarding vs. pre-edge contents.
        step(); drive(2'b01, 5'd7, 32'hDEADBEF6, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd1);
        expect_v(K_RDATA,  0, 32'hDEADBEF6, "bypass_on");
        expect_v(K_RDATAB, 0, 32'h00000000, "bypass_off_old");
        step(); drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd1);
        expect_v(K_RDATA,  0, 32'hDEADBEF6, "x7_after_edge");
        expect_v(K_RDATAB, 0, 32'hDEADBEF6, "x7_nobyp_after_edge");

        // Scoreboard: issue, writeback clears, issue+writeback keeps busy.
        step(); drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd1);
        expect_v(K_BUSY, 0, 32'h0, "busy_before_edge");
        expect_v(K_ANY,  0, 32'h0, "any_before_edge");
        step(); drive(2'b01, 5'd3, 32'h00000033, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd1);
        expect_v(K_BUSY,  0, 32'h1, "busy_after_issue");
        expect_v(K_ANY,   0, 32'h1, "any_after_issue");
        expect_v(K_BUSYB, 0, 32'h1, "busy_nobyp_issue");
        step(); drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd1);
        expect_v(K_BUSY,  0, 32'h0, "busy_cleared");
        expect_v(K_ANY,   0, 32'h0, "any_cleared");
        expect_v(K_RDATA, 0, 32'h00000033, "x3_writeback");
        step(); drive(2'b01, 5'd3, 32'h00000044, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd1);
        step(); drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd3, 5'd1);
        expect_v(K_BUSY, 0, 32'h1, "issue_wins_wb");
        expect_v(K_ANY,  0, 32'h1, "any_issue_wins");
        step(); drive(2'b01, 5'd3, 32'h00000055, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd3);
        expect_v(K_BUSY,  0, 32'h0, "x0_issue_ignored");
        expect_v(K_BUSY,  1, 32'h1, "busy_not_bypassed");
        expect_v(K_RDATA, 1, 32'h00000055, "data_bypassed_busy");
        step(); drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd1);
        expect_v(K_ANY,   0, 32'h0, "any_final_clear");
        expect_v(K_ANYB,  0, 32'h0, "any_nobyp_clear");
        expect_v(K_RDATA, 0, 32'h00000055, "x3_final");

        // Multi-port sweep: x2..x5 = 0xDEADBEEF + index.
        step(); drive(2'b11, 5'd2, 32'hDEADBEF1, 5'd3, 32'hDEADBEF2, 1'b0, 5'd0, 5'd0, 5'd0);
        step(); drive(2'b11, 5'd4, 32'hDEADBEF3, 5'd5, 32'hDEADBEF4, 1'b0, 5'd0, 5'd0, 5'd0);
        step(); drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd2, 5'd5);
        expect_v(K_RDATA, 0, 32'hDEADBEF1, "sweep_x2");
        expect_v(K_RDATA, 1, 32'hDEADBEF4, "sweep_x5");
        step(); drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd3);
        expect_v(K_RDATA, 0, 32'hDEADBEF3, "sweep_x4");
        expect_v(K_RDATA, 1, 32'hDEADBEF2, "sweep_x3");

        // Reset with preloaded state and a pending write: clears without an edge.
        step(); drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd6, 5'd2, 5'd6);
        step(); drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd2, 5'd6);
        expect_v(K_RDATA, 0, 32'hDEADBEF1, "preload_x2");
        expect_v(K_BUSY,  1, 32'h1, "preload_busy6");
        expect_v(K_ANY,   0, 32'h1, "preload_any");
        step();
        reset = 1'b1;
        drive(2'b01, 5'd2, 32'h00000001, 5'd0, 32'h0, 1'b0, 5'd0, 5'd2, 5'd6);
        expect_v(K_RDATA, 0, 32'h0, "async_reset_rdata0");
        expect_v(K_RDATA, 1, 32'h0, "async_reset_rdata1");
        expect_v(K_BUSY,  1, 32'h0, "async_reset_busy");
        expect_v(K_ANY,   0, 32'h0, "async_reset_any");
        expect_v(K_ANYB,  0, 32'h0, "async_reset_any_nobyp");
        step();
        reset = 1'b0;
        drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd2, 5'd5);
        expect_v(K_RDATA, 0, 32'h0, "write_lost_in_reset");
        expect_v(K_RDATA, 1, 32'h0, "x5_cleared");

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10; i++) begin
            if (sb_q.size() > 0) begin
                @(posedge clk);
            end
        end
        if (sb_q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
Parametrised multi-port integer register file, successor to reg_file. It adds configurable width/depth, N read ports, two write ports with fixed priority, optional write-to-read bypass, and a per-register busy scoreboard for in-flight destinations. It sits between decode (read/issue) and writeback in the single-cycle and upcoming pipelined CPU datapaths.

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of architectural registers (power of two, >=2)
AW, 5, address width, must equal log2(NREGS)
NRP, 2, number of read ports (1..4)
BYPASS, 1, 1 = read data forwards same-cycle write data; 0 = reads show pre-edge contents
HARDWIRE_X0, 1, 1 = register 0 reads as zero and ignores writes and issues

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state
rs  input  NRP*AW  read addresses, port i at [i*AW +: AW]
rdata  output  NRP*XLEN  read data, port i at [i*XLEN +: XLEN]
rs_busy  output  NRP  busy bit of register addressed by port i
we  input  2  write enables, port 0 and port 1
rd  input  2*AW  write addresses, port j at [j*AW +: AW]
wd  input  2*XLEN  write data, port j at [j*XLEN +: XLEN]
issue_valid  input  1  mark issue_rd busy (destination in flight)
issue_rd  input  AW  destination register being issued
any_busy  output  1  OR of all busy bits

Behaviour:
- Reset (async, active-high): all registers = 0, all busy bits = 0, immediately on assertion, independent of clk. All rdata = 0, rs_busy = 0, any_busy = 0 while reset is high. Reset mid-write: the write is lost.
- Reads are combinational, zero-cycle latency from rs to rdata and rs_busy.
- Writes: on a rising edge, for each port j with we[j]=1, reg[rd_j] <= wd_j.
- Same-rd conflict (both we set, rd0==rd1): port 1 wins. Port 0 data is discarded.
- HARDWIRE_X0=1: writes to address 0 are ignored. rdata for address 0 is always 0. Issue to 0 is ignored and rs_busy for address 0 is always 0.
- BYPASS=1: if we[j]=1 and rd_j==rs_i (and rs_i is not x0 when hardwired), rdata_i = wd_j in the same cycle, with port 1 taking priority over port 0. Otherwise rdata_i = reg[rs_i].
- BYPASS=0: rdata_i = reg[rs_i]. The new value appears after the edge.
- Scoreboard, per register k, on a rising edge:
  - set if issue_valid and issue_rd==k
  - else clear if any write port has we=1 and rd==k
  - else hold
  - Issue and writeback to the same register in the same cycle leaves busy=1 (the new producer wins).
- rs_busy_i = busy[rs_i]. It is not bypassed: a same-cycle writeback does not hide busy until the edge.
- any_busy = |busy, registered-state derived (combinational OR of flops).
- Out-of-range addresses cannot occur (NREGS = 2^AW). No X propagation is permitted on any output after reset.

Test Plan:
- Assert reset with registers preloaded → all rdata = 0x00000000, any_busy = 0, immediately without a clock edge.
- Write port 0: rd=1, wd=0x12345678. Then read rs0=1 and rs1=1 → both read ports return 0x12345678. Write rd=0, wd=0xFFFFFFFF → x0 still reads 0x00000000.
- Same-cycle conflict: we=2'b11, rd0=rd1=5, wd0=0xAAAA0000, wd1=0x5555FFFF → x5 reads 0x5555FFFF after the edge.
- Bypass: rs0=7, we[0]=1, rd0=7, wd0=0xDEADBEF6 → with BYPASS=1, rdata0 = 0xDEADBEF6 before the edge. Rebuilt with BYPASS=0, it shows the old value (0) until after the edge.
- Scoreboard sequence, issue_rd=3 then:
  - after the edge: rs_busy=1, any_busy=1
  - next cycle, writeback rd0=3 with no issue → busy clears, any_busy=0
  - issue and writeback to reg 3 in the same cycle → busy stays 1
- Multi-port sweep: write x2..x5 = 0xDEADBEEF+i, then read them through all NRP ports simultaneously with different addresses → each port returns its own expected value.
